// File: rtl/memory_v3_if.sv
// Bus bundle for memory_v3: one write port, R read ports, clear-busy flag.
interface memory_v3_if #(
  parameter int M = 8,
  parameter int K = 4,
  parameter int R = 2
);
  logic           we;
  logic [K-1:0]   addrw;
  logic [M-1:0]   Min;
  logic [R*K-1:0] addr;
  logic [R*M-1:0] Mout;
  logic           busy;

  modport master (
    output we, addrw, Min, addr,
    input  Mout, busy
  );

  modport slave (
    input  we, addrw, Min, addr,
    output Mout, busy
  );
endinterface

// File: rtl/memory_v3.sv
// Synchronous memory: one write port, R registered read ports, optional
// write-to-read bypass, and a post-reset clear sweep that loads INIT into
// every word before any access is accepted.
module memory_v3 #(
  parameter int          M      = 8,
  parameter int          K      = 4,
  parameter int          R      = 2,
  parameter int          BYPASS = 1,
  parameter logic [M-1:0] INIT  = '0
) (
  input  logic        clk,
  input  logic        rst,
  memory_v3_if.slave  bus
);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t       state, state_n;
  logic [K:0]   ptr, ptr_n;
  logic         clr_we;
  logic [M-1:0] mem [2**K];

  // State register and clear pointer; reset restarts the sweep at word 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  // Sweep sequencing: one word per edge, READY after the last word
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    clr_we  = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        ptr_n  = ptr + (K+1)'(1);
        if (ptr[K-1:0] == '1) begin
          state_n = READY;
        end
      end
      READY: begin
        state_n = READY;
      end
      default: begin
        state_n = CLEAR;
      end
    endcase
  end

  assign bus.busy = (state == CLEAR);

  // Storage writes: sweep owns the array while clearing, user port otherwise
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[ptr[K-1:0]] <= INIT;
      end else if (bus.we) begin
        mem[bus.addrw] <= bus.Min;
      end
    end
  end

  for (genvar g = 0; g < R; g++) begin : g_port
    logic [K-1:0] ra;
    logic [M-1:0] rd;
    logic [M-1:0] q;

    assign ra = bus.addr[g*K +: K];

    // Read mux; with bypass a same-edge write to this address is forwarded
    always_comb begin
      rd = mem[ra];
      if ((BYPASS != 0) && bus.we && (bus.addrw == ra)) begin
        rd = bus.Min;
      end
    end

    // Registered read port, forced to zero while clearing
    always_ff @(posedge clk) begin
      if (rst || (state == CLEAR)) begin
        q <= '0;
      end else begin
        q <= rd;
      end
    end

    assign bus.Mout[g*M +: M] = q;
  end

endmodule
